// File: rtl/ppu_quant_if.sv
// Output-side valid/ready stream of ppu_quant: one packed, requantized row per beat.
interface ppu_quant_if #(
  parameter int unsigned LANES = 16,
  parameter int unsigned OUT_W = 8
);
  logic                   valid;
  logic                   ready;
  logic [LANES*OUT_W-1:0] data;
  logic [3:0]             row;
  logic                   tile_last;

  modport master (output valid, output data, output row, output tile_last, input ready);
  modport slave  (input valid, input data, input row, input tile_last, output ready);
endinterface

// File: rtl/ppu_quant.sv
// Post-processing unit: captures a 16-row accumulator tile, requantizes each lane
// (scale, round-half-up shift, saturate to INT8/INT4) and queues packed rows in a FIFO.
// Optional feature macro: PPU_RELU_EN (clamps negative results to zero when i_relu latched).
module ppu_quant #(
  parameter int unsigned LANES = 16,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SC_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned ROWS  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_mode,
  input  logic [SC_W-1:0]        i_scale,
  input  logic [4:0]             i_shift,
  input  logic                   i_relu,
  input  logic                   i_ppu_start,
  input  logic [LANES*ACC_W-1:0] i_acc_data,
  ppu_quant_if.master            out_if,
  output logic                   o_busy,
  output logic                   o_ovf
);
  localparam int unsigned RowW   = $clog2(ROWS);
  localparam int unsigned ProdW  = ACC_W + SC_W + 1;
  localparam int unsigned RndW   = ProdW + 1;
  localparam int unsigned CntW   = RowW + 1;

  typedef enum logic [0:0] {StIdle, StCap} state_e;

  state_e            state_q;
  logic [RowW-1:0]   cap_row_q;
  logic [1:0]        mode_q;
  logic [SC_W-1:0]   scale_q;
  logic [4:0]        shift_q;
  logic              relu_q;

  logic              cap_active;
  logic              cap_last;
  logic              start_err;

  assign cap_active = (state_q == StCap);
  assign cap_last   = (cap_row_q == RowW'(ROWS - 1));
  // A start is only legal while idle or alongside the final row of the current tile.
  assign start_err  = cap_active && i_ppu_start && !cap_last;

  // Capture FSM: tracks row index and latches per-tile configuration on each accepted start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cap_row_q <= '0;
      mode_q    <= '0;
      scale_q   <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_ppu_start) begin
            state_q   <= StCap;
            cap_row_q <= '0;
            mode_q    <= i_mode;
            scale_q   <= i_scale;
            shift_q   <= i_shift;
            relu_q    <= i_relu;
          end
        end
        StCap: begin
          if (cap_last) begin
            cap_row_q <= '0;
            if (i_ppu_start) begin
              mode_q  <= i_mode;
              scale_q <= i_scale;
              shift_q <= i_shift;
              relu_q  <= i_relu;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cap_row_q <= cap_row_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stage 1: per-lane multiply; tile config travels with the row so back-to-back tiles
  // never see the next tile's shift/mode.
  logic                    s1_valid_q;
  logic signed [ProdW-1:0] s1_prod_q [LANES];
  logic [RowW-1:0]         s1_row_q;
  logic [1:0]              s1_mode_q;
  logic [4:0]              s1_shift_q;
  logic                    s1_relu_q;

  // Stage 1 register: sample the accumulator row while capturing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_mode_q  <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      for (int g = 0; g < LANES; g++) s1_prod_q[g] <= '0;
    end else begin
      s1_valid_q <= cap_active;
      if (cap_active) begin
        s1_row_q   <= cap_row_q;
        s1_mode_q  <= mode_q;
        s1_shift_q <= shift_q;
        s1_relu_q  <= relu_q;
        for (int g = 0; g < LANES; g++) begin
          s1_prod_q[g] <= ProdW'($signed(i_acc_data[g*ACC_W +: ACC_W]))
                        * ProdW'($signed({1'b0, scale_q}));
        end
      end
    end
  end

  logic [LANES*OUT_W-1:0] q_data;
  logic signed [RndW-1:0] ext, bias, rnd, hi, lo;
  logic                   int4;

  // Stage 2 combinational: round-half-up shift, optional ReLU, saturate.
  always_comb begin
    q_data = '0;
    ext    = '0;
    bias   = '0;
    rnd    = '0;
    int4   = (s1_mode_q == 2'd1) || (s1_mode_q == 2'd2);
    hi     = int4 ? RndW'(7) : RndW'(127);
    lo     = int4 ? RndW'(-8) : RndW'(-128);
    for (int g = 0; g < LANES; g++) begin
      ext  = RndW'(s1_prod_q[g]);
      bias = (s1_shift_q == 5'd0) ? '0 : (RndW'(1) <<< (s1_shift_q - 5'd1));
      rnd  = (ext + bias) >>> s1_shift_q;
`ifdef PPU_RELU_EN
      if (s1_relu_q && (rnd < 0)) rnd = '0;
`else
      if (s1_relu_q && 1'b0) rnd = '0;
`endif
      if (rnd > hi) begin
        q_data[g*OUT_W +: OUT_W] = hi[OUT_W-1:0];
      end else if (rnd < lo) begin
        q_data[g*OUT_W +: OUT_W] = lo[OUT_W-1:0];
      end else begin
        q_data[g*OUT_W +: OUT_W] = rnd[OUT_W-1:0];
      end
    end
  end

  logic                   s2_valid_q;
  logic [LANES*OUT_W-1:0] s2_data_q;
  logic [RowW-1:0]        s2_row_q;

  // Stage 2 register: quantized packed row awaiting FIFO write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_row_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= q_data;
        s2_row_q  <= s1_row_q;
      end
    end
  end

  logic [LANES*OUT_W-1:0] mem_data [ROWS];
  logic [RowW-1:0]        mem_row  [ROWS];
  logic [RowW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   fifo_full, fifo_pop, fifo_push, fifo_drop;

  assign fifo_full = (count_q == CntW'(ROWS));
  assign fifo_pop  = out_if.valid && out_if.ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign fifo_push = s2_valid_q && (!fifo_full || fifo_pop);
  assign fifo_drop = s2_valid_q && fifo_full && !fifo_pop;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (fifo_push) begin
      mem_data[wr_ptr_q] <= s2_data_q;
      mem_row[wr_ptr_q]  <= s2_row_q;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (fifo_push && !fifo_pop)      count_q <= count_q + 1'b1;
      else if (!fifo_push && fifo_pop) count_q <= count_q - 1'b1;
    end
  end

  // Sticky error: illegal start or a row lost to a full FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf <= 1'b0;
    end else if (start_err || fifo_drop) begin
      o_ovf <= 1'b1;
    end
  end

  // Head-of-FIFO outputs, forced to zero when empty so reset/idle outputs are clean.
  always_comb begin
    out_if.valid     = (count_q != '0);
    out_if.data      = out_if.valid ? mem_data[rd_ptr_q] : '0;
    out_if.row       = out_if.valid ? mem_row[rd_ptr_q] : '0;
    out_if.tile_last = out_if.valid && (mem_row[rd_ptr_q] == RowW'(ROWS - 1));
    o_busy           = cap_active || s1_valid_q || s2_valid_q || (count_q != '0);
  end
endmodule

// File: tb/tb_ppu_quant.sv
module tb_ppu_quant;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   mode;
  logic [15:0]  scale;
  logic [4:0]   shift;
  logic         relu;
  logic         start;
  logic [383:0] acc;
  logic         busy;
  logic         ovf;

  ppu_quant_if #(.LANES(16), .OUT_W(8)) oif ();

  ppu_quant dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode),
    .i_scale     (scale),
    .i_shift     (shift),
    .i_relu      (relu),
    .i_ppu_start (start),
    .i_acc_data  (acc),
    .out_if      (oif),
    .o_busy      (busy),
    .o_ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   row;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted beat is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && oif.valid && oif.ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_row", 128'd1, 128'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("row_data", oif.data, mon_e.data);
        chk("row_idx", 128'(oif.row), 128'(mon_e.row));
        chk("tile_last", 128'(oif.tile_last), 128'(mon_e.row == 4'd15));
      end
    end
  end

  // Stimulus patterns: 0 ramp g+r, 1 rounding/saturation corners, 2 ReLU corners.
  function automatic logic [383:0] row_acc(input int pat, input int r);
    logic [383:0] a;
    a = '0;
    if (pat == 0) begin
      for (int g = 0; g < 16; g++) a[g*24 +: 24] = 24'(g + r);
    end else if (pat == 1) begin
      a[0  +: 24] = 24'sd5;
      a[24 +: 24] = -24'sd5;
      a[48 +: 24] = 24'sd100000;
      a[72 +: 24] = -24'sd100000;
    end else begin
      a[0  +: 24] = -24'sd50;
      a[24 +: 24] = 24'sd50;
    end
    return a;
  endfunction

  function automatic logic [127:0] exp_row(input int pat, input logic [1:0] m,
                                           input logic rl, input int r);
    logic [127:0] e;
    e = '0;
    if (pat == 0) begin
      for (int g = 0; g < 16; g++) e[g*8 +: 8] = 8'(g + r);
    end else if (pat == 1) begin
      // lanes 0..3: 4, -4, sat-hi, sat-lo
      e[31:0] = ((m == 2'd1) || (m == 2'd2)) ? 32'hF807FC04 : 32'h807FFC04;
    end else begin
`ifdef PPU_RELU_EN
      e[15:0] = rl ? 16'h3200 : 16'h32CE;
`else
      e[15:0] = 16'h32CE;
`endif
    end
    return e;
  endfunction

  // Drives ntiles back-to-back tiles; xs = cycle of an extra start, rst_at = cycle to reset.
  task automatic run(input int pat, input logic [1:0] m, input logic [15:0] sc,
                     input logic [4:0] sh, input logic rl, input int ntiles,
                     input int limit, input int xs, input bit lat_chk, input int rst_at);
    int pushed = 0;
    for (int c = 0; c <= 16 * ntiles; c++) begin
      if (c == rst_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_valid", 128'(oif.valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ovf", 128'(ovf), 128'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      start = ((c % 16 == 0) && (c < 16 * ntiles)) || (c == xs);
      if (c % 16 == 0) begin
        mode  = m;
        scale = sc;
        shift = sh;
        relu  = rl;
      end else begin
        // Config noise mid-tile must not affect results.
        mode  = ~m;
        scale = ~sc;
        shift = sh + 5'd5;
        relu  = ~rl;
      end
      if (c >= 1) begin
        acc = row_acc(pat, (c - 1) % 16);
        if (pushed < limit) begin
          exp_q.push_back('{data: exp_row(pat, m, rl, (c - 1) % 16), row: 4'((c - 1) % 16)});
          pushed++;
        end
      end else begin
        acc = '0;
      end
      if (lat_chk && c == 3) chk("latency_t3", 128'(oif.valid), 128'd0);
      if (lat_chk && c == 4) chk("latency_t4", 128'(oif.valid), 128'd1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    acc   = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
    chk({name, "_idle"}, 128'(busy), 128'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    mode      = '0;
    scale     = '0;
    shift     = '0;
    relu      = 1'b0;
    start     = 1'b0;
    acc       = '0;
    oif.ready = 1'b1;
    #1;
    chk("reset_valid", 128'(oif.valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_ovf", 128'(ovf), 128'd0);
    chk("reset_data", oif.data, 128'd0);
    chk("reset_row", 128'(oif.row), 128'd0);
    chk("reset_last", 128'(oif.tile_last), 128'd0);
    wait_cycles(3);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(2);

    // INT8 ramp with latency check
    run(0, 2'd0, 16'd1, 5'd0, 1'b0, 1, 16, -1, 1'b1, -1);
    drain("int8_ramp");
    chk("int8_ramp_ovf", 128'(ovf), 128'd0);

    // Rounding and saturation in every mode encoding
    for (int m = 0; m < 4; m++) begin
      run(1, 2'(m), 16'd3, 5'd2, 1'b0, 1, 16, -1, 1'b0, -1);
      drain("round_sat");
    end

    // Backpressure: 40 stalled cycles, FIFO holds the whole tile
    oif.ready = 1'b0;
    run(0, 2'd0, 16'd1, 5'd0, 1'b0, 1, 16, -1, 1'b0, -1);
    wait_cycles(23);
    chk("stall_valid", 128'(oif.valid), 128'd1);
    chk("stall_head_row", 128'(oif.row), 128'd0);
    chk("stall_head_data", oif.data, exp_row(0, 2'd0, 1'b0, 0));
    chk("stall_ovf", 128'(ovf), 128'd0);
    oif.ready = 1'b1;
    drain("stall");

    // Overflow: two tiles with no drain, second tile dropped
    oif.ready = 1'b0;
    run(0, 2'd0, 16'd1, 5'd0, 1'b0, 2, 16, -1, 1'b0, -1);
    wait_cycles(5);
    chk("overflow_ovf", 128'(ovf), 128'd1);
    oif.ready = 1'b1;
    drain("overflow");
    chk("overflow_ovf_sticky", 128'(ovf), 128'd1);

    // Reset mid-tile clears everything, fresh tile afterwards
    run(0, 2'd0, 16'd1, 5'd0, 1'b0, 1, 16, -1, 1'b0, 9);
    chk("post_reset_valid", 128'(oif.valid), 128'd0);
    run(0, 2'd0, 16'd1, 5'd0, 1'b0, 1, 16, -1, 1'b0, -1);
    drain("post_reset");
    chk("post_reset_ovf", 128'(ovf), 128'd0);

    // Back-to-back tiles, no error
    run(0, 2'd0, 16'd1, 5'd0, 1'b0, 2, 32, -1, 1'b0, -1);
    drain("b2b");
    chk("b2b_ovf", 128'(ovf), 128'd0);

    // Extra start mid-capture is ignored but flagged
    run(0, 2'd0, 16'd1, 5'd0, 1'b0, 1, 16, 8, 1'b0, -1);
    drain("extra_start");
    chk("extra_start_ovf", 128'(ovf), 128'd1);

    // ReLU on and off
    run(2, 2'd0, 16'd1, 5'd0, 1'b1, 1, 16, -1, 1'b0, -1);
    drain("relu_on");
    run(2, 2'd0, 16'd1, 5'd0, 1'b0, 1, 16, -1, 1'b0, -1);
    drain("relu_off");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
